// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multi-cycle CPU.
// Sequences each instruction through IF/ID/EXE/MEM/WB and decodes the
// datapath controls from (state, opcode). Also exposes the halt,
// sticky illegal-opcode and retired-instruction status.
module multicycle_ctrl #(
    parameter int HALT_ON_ILLEGAL = 1,
    parameter int CNT_W           = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Run,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             sign,
    output logic [2:0]       state,
    output logic             PCWre,
    output logic             IRWre,
    output logic             RegWre,
    output logic [1:0]       RegDst,
    output logic             DBDataSrc,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic             ExtSel,
    output logic             mRD,
    output logic             mWR,
    output logic [1:0]       PCSrc,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_WB   = 3'b011,
        S_MEM  = 3'b100,
        S_HALT = 3'b111
    } stateT;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_XORI  = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b100110;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic haltOnIllegal = (HALT_ON_ILLEGAL != 0);

    stateT curState;
    stateT nextState;

    // opcode class flags
    logic isRType;
    logic isImm;
    logic isLw;
    logic isSw;
    logic isBranch;
    logic branchTaken;
    logic isJ;
    logic isJr;
    logic isJal;
    logic isHalt;
    logic isLegal;
    logic [2:0] aluOpDec;

    // control qualifiers
    logic advance;
    logic retireCycle;

    // Classify the opcode into instruction groups and pick the ALU operation.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        isRType     = 1'b0;
        isImm       = 1'b0;
        isLw        = 1'b0;
        isSw        = 1'b0;
        isBranch    = 1'b0;
        branchTaken = 1'b0;
        isJ         = 1'b0;
        isJr        = 1'b0;
        isJal       = 1'b0;
        isHalt      = 1'b0;
        isLegal     = 1'b1;
        aluOpDec    = 3'b000;
        case (opcode)
            OP_ADD:   begin isRType = 1'b1; aluOpDec = 3'b000; end
            OP_SUB:   begin isRType = 1'b1; aluOpDec = 3'b001; end
            OP_AND:   begin isRType = 1'b1; aluOpDec = 3'b010; end
            OP_SLL:   begin isRType = 1'b1; aluOpDec = 3'b101; end
            OP_ADDIU: begin isImm   = 1'b1; aluOpDec = 3'b000; end
            OP_ANDI:  begin isImm   = 1'b1; aluOpDec = 3'b010; end
            OP_ORI:   begin isImm   = 1'b1; aluOpDec = 3'b011; end
            OP_XORI:  begin isImm   = 1'b1; aluOpDec = 3'b100; end
            OP_SLTI:  begin isImm   = 1'b1; aluOpDec = 3'b110; end
            OP_LW:    begin isLw    = 1'b1; aluOpDec = 3'b000; end
            OP_SW:    begin isSw    = 1'b1; aluOpDec = 3'b000; end
            OP_BEQ:   begin isBranch = 1'b1; branchTaken = zero;  aluOpDec = 3'b001; end
            OP_BNE:   begin isBranch = 1'b1; branchTaken = !zero; aluOpDec = 3'b001; end
            // bltz tests the sign of rs - $0
            OP_BLTZ:  begin isBranch = 1'b1; branchTaken = sign;  aluOpDec = 3'b001; end
            OP_J:     isJ    = 1'b1;
            OP_JR:    isJr   = 1'b1;
            OP_JAL:   isJal  = 1'b1;
            OP_HALT:  isHalt = 1'b1;
            default:  isLegal = 1'b0;
        endcase
    end

    assign advance = Run && !RST;

    // Flag the last cycle of each instruction flow, where the PC is loaded and the instruction retires.
    always_comb begin
        retireCycle = 1'b0;
        case (curState)
            S_WB:    retireCycle = 1'b1;
            S_MEM:   retireCycle = isSw;
            S_EXE:   retireCycle = isBranch;
            S_ID:    retireCycle = isJ || isJr || isJal || (!isLegal && !haltOnIllegal);
            default: retireCycle = 1'b0;
        endcase
    end

    // Next-state selection; Run=0 freezes the current state.
    always_comb begin
        nextState = curState;
        if (Run) begin
            case (curState)
                S_IF: nextState = S_ID;
                S_ID: begin
                    if (!isLegal)
                        nextState = haltOnIllegal ? S_HALT : S_IF;
                    else if (isHalt)
                        nextState = S_HALT;
                    else if (isJ || isJr || isJal)
                        nextState = S_IF;
                    else
                        nextState = S_EXE;
                end
                S_EXE: begin
                    if (isLw || isSw)
                        nextState = S_MEM;
                    else if (isRType || isImm)
                        nextState = S_WB;
                    else
                        nextState = S_IF;
                end
                S_MEM:   nextState = isLw ? S_WB : S_IF;
                S_WB:    nextState = S_IF;
                S_HALT:  nextState = S_HALT;
                default: nextState = S_IF;
            endcase
        end
    end

    // State register with synchronous reset that aborts any instruction in flight.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (RST)
            curState <= S_IF;
        else
            curState <= nextState;
    end

    // Sticky illegal-opcode flag, set when an undefined opcode is decoded in ID.
    always_ff @(posedge CLK) begin
        if (RST)
            illegal <= 1'b0;
        else if (Run && curState == S_ID && !isLegal)
            illegal <= 1'b1;
    end

    // Retired-instruction counter; bumps on each advancing edge out of a retire cycle and wraps.
    always_ff @(posedge CLK) begin
        if (RST)
            retired <= '0;
        else if (advance && retireCycle)
            retired <= retired + CNT_W'(1);
    end

    // Datapath control decode from (state, opcode); write enables are gated by Run and RST.
    always_comb begin
        PCWre     = advance && retireCycle;
        IRWre     = advance && (curState == S_IF);
        RegWre    = advance && (((curState == S_WB) && (isRType || isImm || isLw)) ||
                                ((curState == S_ID) && isJal));
        mWR       = advance && (curState == S_MEM) && isSw;
        mRD       = (curState == S_MEM) && isLw;
        RegDst    = isJal ? 2'b00 : (isRType ? 2'b10 : 2'b01);
        DBDataSrc = isLw;
        ALUSrcA   = (opcode == OP_SLL);
        ALUSrcB   = isImm || isLw || isSw;
        ALUOp     = aluOpDec;
        ExtSel    = (opcode == OP_ADDIU) || (opcode == OP_SLTI) || isLw || isSw || isBranch;
        PCSrc     = 2'b00;
        if (curState == S_ID) begin
            if (isJ || isJal)
                PCSrc = 2'b11;
            else if (isJr)
                PCSrc = 2'b10;
        end else if (curState == S_EXE && isBranch && branchTaken) begin
            PCSrc = 2'b01;
        end
        halted    = (curState == S_HALT);
    end

    assign state = curState;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    logic             CLK;
    logic             RST;
    logic             Run;
    logic [5:0]       opcode;
    logic             zero;
    logic             sign;
    logic [2:0]       state;
    logic             PCWre;
    logic             IRWre;
    logic             RegWre;
    logic [1:0]       RegDst;
    logic             DBDataSrc;
    logic             ALUSrcA;
    logic             ALUSrcB;
    logic [2:0]       ALUOp;
    logic             ExtSel;
    logic             mRD;
    logic             mWR;
    logic [1:0]       PCSrc;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    int tests = 0;
    int fails = 0;

    multicycle_ctrl #(.HALT_ON_ILLEGAL(1), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .Run(Run), .opcode(opcode), .zero(zero), .sign(sign),
        .state(state), .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst),
        .DBDataSrc(DBDataSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ExtSel(ExtSel), .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc), .halted(halted),
        .illegal(illegal), .retired(retired)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock and sample 1 time unit after the edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; Run = 1'b0; opcode = 6'b000000; zero = 1'b0; sign = 1'b0;

        // reset
        step();
        check("rst_state",  32'(state), 0);
        check("rst_irwre",  32'(IRWre), 0);
        check("rst_pcwre",  32'(PCWre), 0);
        check("rst_ill",    32'(illegal), 0);
        check("rst_ret",    32'(retired), 0);
        RST = 1'b0; Run = 1'b1; #1;

        // add: IF ID EXE WB IF
        check("add_if",     32'(state), 0);
        check("add_if_ir",  32'(IRWre), 1);
        check("add_if_reg", 32'(RegWre), 0);
        step();
        check("add_id",     32'(state), 1);
        check("add_id_reg", 32'(RegWre), 0);
        check("add_id_pc",  32'(PCWre), 0);
        step();
        check("add_exe",    32'(state), 2);
        check("add_exe_reg",32'(RegWre), 0);
        check("add_aluop",  32'(ALUOp), 0);
        step();
        check("add_wb",     32'(state), 3);
        check("add_wb_reg", 32'(RegWre), 1);
        check("add_wb_dst", 32'(RegDst), 2);
        check("add_wb_pc",  32'(PCWre), 1);
        check("add_wb_db",  32'(DBDataSrc), 0);
        step();
        check("add_end",    32'(state), 0);
        check("add_ret",    32'(retired), 1);
        check("add_end_pc", 32'(PCWre), 0);

        // lw: IF ID EXE MEM WB IF
        opcode = 6'b110001; #1;
        check("lw_ext",     32'(ExtSel), 1);
        check("lw_srcb",    32'(ALUSrcB), 1);
        step(); check("lw_id",  32'(state), 1);
        step(); check("lw_exe", 32'(state), 2);
        step();
        check("lw_mem",     32'(state), 4);
        check("lw_mem_rd",  32'(mRD), 1);
        check("lw_mem_wr",  32'(mWR), 0);
        check("lw_mem_reg", 32'(RegWre), 0);
        step();
        check("lw_wb",      32'(state), 3);
        check("lw_wb_reg",  32'(RegWre), 1);
        check("lw_wb_db",   32'(DBDataSrc), 1);
        check("lw_wb_dst",  32'(RegDst), 1);
        step();
        check("lw_end",     32'(state), 0);
        check("lw_ret",     32'(retired), 2);

        // sw: IF ID EXE MEM IF, never writes the register file
        opcode = 6'b110000; #1;
        check("sw_if_reg",  32'(RegWre), 0);
        step(); check("sw_id_reg",  32'(RegWre), 0);
        step(); check("sw_exe_reg", 32'(RegWre), 0);
        step();
        check("sw_mem",     32'(state), 4);
        check("sw_mem_wr",  32'(mWR), 1);
        check("sw_mem_rd",  32'(mRD), 0);
        check("sw_mem_reg", 32'(RegWre), 0);
        check("sw_mem_pc",  32'(PCWre), 1);
        step();
        check("sw_end",     32'(state), 0);
        check("sw_ret",     32'(retired), 3);

        // beq taken
        opcode = 6'b110100; zero = 1'b1;
        step(); step();
        check("beqt_exe",   32'(state), 2);
        check("beqt_src",   32'(PCSrc), 1);
        check("beqt_pc",    32'(PCWre), 1);
        step();
        check("beqt_end",   32'(state), 0);
        check("beqt_ret",   32'(retired), 4);

        // beq not taken
        zero = 1'b0;
        step(); step();
        check("beqn_src",   32'(PCSrc), 0);
        check("beqn_pc",    32'(PCWre), 1);
        step();
        check("beqn_end",   32'(state), 0);

        // bltz taken on sign
        opcode = 6'b110110; sign = 1'b1;
        step(); step();
        check("bltz_src",   32'(PCSrc), 1);
        step();
        sign = 1'b0;
        check("bltz_ret",   32'(retired), 6);

        // jal: retires in ID with $31 write
        opcode = 6'b111010;
        step();
        check("jal_id",     32'(state), 1);
        check("jal_reg",    32'(RegWre), 1);
        check("jal_dst",    32'(RegDst), 0);
        check("jal_src",    32'(PCSrc), 3);
        check("jal_pc",     32'(PCWre), 1);
        step();
        check("jal_end",    32'(state), 0);
        check("jal_ret",    32'(retired), 7);

        // jr
        opcode = 6'b111001;
        step();
        check("jr_src",     32'(PCSrc), 2);
        check("jr_reg",     32'(RegWre), 0);
        step();
        check("jr_ret",     32'(retired), 8);

        // Run=0 held in WB of ori
        opcode = 6'b010010;
        step(); step(); step();
        check("hold_wb",    32'(state), 3);
        Run = 1'b0; #1;
        check("hold_reg0",  32'(RegWre), 0);
        check("hold_pc0",   32'(PCWre), 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_state", 32'(state), 3);
            check("hold_reg",   32'(RegWre), 0);
            check("hold_ret",   32'(retired), 8);
        end
        Run = 1'b1; #1;
        check("resume_reg", 32'(RegWre), 1);
        check("resume_dst", 32'(RegDst), 1);
        step();
        check("resume_end", 32'(state), 0);
        check("resume_reg1",32'(RegWre), 0);
        check("resume_ret", 32'(retired), 9);

        // RST during MEM of lw aborts the instruction
        opcode = 6'b110001;
        step(); step(); step();
        check("abort_mem",  32'(state), 4);
        RST = 1'b1; #1;
        check("abort_reg",  32'(RegWre), 0);
        check("abort_pc",   32'(PCWre), 0);
        step();
        check("abort_st",   32'(state), 0);
        check("abort_ret",  32'(retired), 0);
        check("abort_ir",   32'(IRWre), 0);
        RST = 1'b0; #1;

        // j repeated 16 times wraps the 4-bit counter
        opcode = 6'b111000;
        for (int i = 0; i < 16; i++) begin
            step(); step();
        end
        check("wrap_state", 32'(state), 0);
        check("wrap_ret",   32'(retired), 0);
        step();
        check("j_src",      32'(PCSrc), 3);
        step();
        check("wrap_ret1",  32'(retired), 1);

        // illegal opcode enters HALT and stays
        opcode = 6'b101010;
        step();
        check("ill_id",     32'(state), 1);
        check("ill_id_pc",  32'(PCWre), 0);
        check("ill_id_flag",32'(illegal), 0);
        step();
        check("ill_halt",   32'(state), 7);
        check("ill_flag",   32'(illegal), 1);
        check("ill_halted", 32'(halted), 1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("ill_hold",   32'(state), 7);
            check("ill_hold_pc",32'(PCWre), 0);
            check("ill_hold_ir",32'(IRWre), 0);
        end
        check("ill_ret",    32'(retired), 1);
        RST = 1'b1;
        step();
        RST = 1'b0; #1;
        check("ill_rst_st", 32'(state), 0);
        check("ill_rst_fl", 32'(illegal), 0);
        check("ill_rst_hl", 32'(halted), 0);

        // halt opcode: IF ID HALT, no retire, not illegal
        opcode = 6'b111111;
        step(); step();
        check("halt_state", 32'(state), 7);
        check("halt_ill",   32'(illegal), 0);
        check("halt_ret",   32'(retired), 0);
        step();
        check("halt_keep",  32'(state), 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
